// File: rtl/bus_arbiter.sv
// bus_arbiter: Zorro II DMA arbiter handing the bus from the accelerator 68000 to a motherboard DMA master
module bus_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int HOLDOFF = 8
) (
   input  logic C7M,
   input  logic RESET_n,
   input  logic BR_MB_n,
   input  logic BGACK_MB_n,
   input  logic BG_CPU_n,
   input  logic AS_CPU_n,
   output logic BR_CPU_n,
   output logic BG_MB_n,
   output logic BGACK_CPU_n,
   output logic DMA_ACTIVE,
   output logic ARB_TIMEOUT
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] GRANT   = 3'd2;
   localparam logic [2:0] ACK     = 3'd3;
   localparam logic [2:0] OWN     = 3'd4;
   localparam logic [2:0] RELEASE = 3'd5;

   logic [3:0] sync1, sync2;
   logic       br_s, bgack_s, bg_s, as_s;
   logic [2:0] state, state_nxt;
   logic [7:0] hold, tcnt;
   logic       expire;

   assign {br_s, bgack_s, bg_s, as_s} = sync2;

   // two-flop synchronizers for the asynchronous bus signals, idling at the negated level
   always_ff @(posedge C7M) begin
      if (!RESET_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {BR_MB_n, BGACK_MB_n, BG_CPU_n, AS_CPU_n};
         sync2 <= sync1;
      end
   end

   // next-state decode; an acknowledge in GRANT beats both withdrawal and expiry
   always_comb begin
      state_nxt = state;
      expire    = 1'b0;
      case (state)
         IDLE:  if (!br_s && hold == 8'd0) state_nxt = REQ;
         REQ:   if (br_s) state_nxt = IDLE;
                else if (!bg_s && as_s && bgack_s) state_nxt = GRANT;
         GRANT: if (!bgack_s) state_nxt = ACK;
                else if (br_s) state_nxt = IDLE;
                else if (tcnt == 8'(TIMEOUT - 1)) begin
                   state_nxt = IDLE;
                   expire    = 1'b1;
                end
         ACK:   state_nxt = OWN;
         OWN:   if (bgack_s) state_nxt = RELEASE;
         default: state_nxt = IDLE;
      endcase
   end

   // state, hold-off/timeout counters, and outputs registered from the next state
   always_ff @(posedge C7M) begin
      if (!RESET_n) begin
         state       <= IDLE;
         hold        <= 8'd0;
         tcnt        <= 8'd0;
         BR_CPU_n    <= 1'b1;
         BG_MB_n     <= 1'b1;
         BGACK_CPU_n <= 1'b1;
         DMA_ACTIVE  <= 1'b0;
         ARB_TIMEOUT <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold        <= (state_nxt == IDLE && (state == GRANT || state == RELEASE)) ? 8'(HOLDOFF) :
                        (state == IDLE && hold != 8'd0) ? hold - 8'd1 : hold;
         tcnt        <= (state == GRANT) ? tcnt + 8'd1 : 8'd0;
         BR_CPU_n    <= !(state_nxt inside {REQ, GRANT, ACK});
         BG_MB_n     <= state_nxt != GRANT;
         BGACK_CPU_n <= !(state_nxt inside {ACK, OWN});
         DMA_ACTIVE  <= state_nxt inside {ACK, OWN};
         ARB_TIMEOUT <= expire;
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: timed vectors, corner sequences and random traffic against a phase/age reference model
module tb_bus_arbiter;
   typedef struct {
      logic [3:0] stim;
      int         e;
      logic [4:0] want;
   } vec_t;
   typedef enum int {P_IDLE, P_REQ, P_GRANT, P_ACK, P_OWN, P_REL} ph_e;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic br_mb = 1'b1, bgack_mb = 1'b1, bg_cpu = 1'b1, as_cpu = 1'b1;
   wire [4:0] o0, o1;
   int checks = 0, errors = 0, cyc = 0;

   ph_e        m_ph[2];
   int         m_age[2], m_need[2];
   logic [3:0] m_da[2], m_db[2];
   logic [4:0] m_out[2];

   always #5 clk = ~clk;

   bus_arbiter dut (
      .C7M(clk), .RESET_n(rst_n), .BR_MB_n(br_mb), .BGACK_MB_n(bgack_mb), .BG_CPU_n(bg_cpu), .AS_CPU_n(as_cpu),
      .BR_CPU_n(o0[4]), .BG_MB_n(o0[3]), .BGACK_CPU_n(o0[2]), .DMA_ACTIVE(o0[1]), .ARB_TIMEOUT(o0[0])
   );

   bus_arbiter #(.TIMEOUT(5), .HOLDOFF(0)) dut0 (
      .C7M(clk), .RESET_n(rst_n), .BR_MB_n(br_mb), .BGACK_MB_n(bgack_mb), .BG_CPU_n(bg_cpu), .AS_CPU_n(as_cpu),
      .BR_CPU_n(o1[4]), .BG_MB_n(o1[3]), .BGACK_CPU_n(o1[2]), .DMA_ACTIVE(o1[1]), .ARB_TIMEOUT(o1[0])
   );

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, want);
      end
   endtask

   // Reference: phase plus edges spent in it; inputs seen two edges late; outputs follow the new phase
   task automatic mstep(input int k, input int ho, input int to, input logic [3:0] now, input logic r);
      logic br, bgack, bg, as_i, tmo;
      ph_e nx;
      tmo = 1'b0;
      if (!r) begin
         m_ph[k] = P_IDLE;
         m_age[k] = 0;
         m_need[k] = 0;
         m_da[k] = '1;
         m_db[k] = '1;
         m_out[k] = 5'b11100;
         return;
      end
      {br, bgack, bg, as_i} = m_da[k];
      m_da[k] = m_db[k];
      m_db[k] = now;
      m_age[k]++;
      nx = m_ph[k];
      case (m_ph[k])
         P_IDLE:  if (!br && m_age[k] > m_need[k]) nx = P_REQ;
         P_REQ:   if (br) nx = P_IDLE; else if (!bg && as_i && bgack) nx = P_GRANT;
         P_GRANT: if (!bgack) nx = P_ACK;
                  else if (br) nx = P_IDLE;
                  else if (m_age[k] == to) begin
                     nx = P_IDLE;
                     tmo = 1'b1;
                  end
         P_ACK:   nx = P_OWN;
         P_OWN:   if (bgack) nx = P_REL;
         default: nx = P_IDLE;
      endcase
      if (nx != m_ph[k]) begin
         m_need[k] = (m_ph[k] == P_GRANT || m_ph[k] == P_REL) ? ho : 0;
         m_age[k] = 0;
         m_ph[k] = nx;
      end
      m_out[k] = {!(nx inside {P_REQ, P_GRANT, P_ACK}), nx != P_GRANT, !(nx inside {P_ACK, P_OWN}),
                  nx inside {P_ACK, P_OWN}, tmo};
   endtask

   task automatic tick();
      logic [3:0] now;
      logic r;
      now = {br_mb, bgack_mb, bg_cpu, as_cpu};
      r = rst_n;
      @(posedge clk);
      mstep(0, 8, 64, now, r);
      mstep(1, 0, 5, now, r);
      #1;
      cyc++;
      chk("model_ho8", o0, m_out[0]);
      chk("model_ho0", o1, m_out[1]);
   endtask

   initial begin
      vec_t vq[$];
      // stim = {BR_MB_n, BGACK_MB_n, BG_CPU_n, AS_CPU_n}, driven from edge e(prev)+1
      // want = {BR_CPU_n, BG_MB_n, BGACK_CPU_n, DMA_ACTIVE, ARB_TIMEOUT} just after edge e
      vq.push_back('{4'b1111,   9, 5'b11100});
      vq.push_back('{4'b0111,  11, 5'b11100});
      vq.push_back('{4'b0111,  12, 5'b01100});
      vq.push_back('{4'b0111,  13, 5'b01100});
      vq.push_back('{4'b0101,  15, 5'b01100});
      vq.push_back('{4'b0101,  16, 5'b00100});
      vq.push_back('{4'b0101,  19, 5'b00100});
      vq.push_back('{4'b0001,  21, 5'b00100});
      vq.push_back('{4'b0001,  22, 5'b01010});
      vq.push_back('{4'b0001,  23, 5'b11010});
      vq.push_back('{4'b1011,  39, 5'b11010});
      vq.push_back('{4'b1111,  41, 5'b11010});
      vq.push_back('{4'b1111,  42, 5'b11100});
      vq.push_back('{4'b0111,  50, 5'b11100});
      vq.push_back('{4'b0111,  52, 5'b01100});
      vq.push_back('{4'b1111,  54, 5'b01100});
      vq.push_back('{4'b1111,  55, 5'b11100});
      vq.push_back('{4'b0111,  57, 5'b11100});
      vq.push_back('{4'b0111,  58, 5'b01100});
      vq.push_back('{4'b0100,  69, 5'b01100});
      vq.push_back('{4'b0101,  71, 5'b01100});
      vq.push_back('{4'b0101,  72, 5'b00100});
      vq.push_back('{4'b0101, 135, 5'b00100});
      vq.push_back('{4'b0101, 136, 5'b11101});
      vq.push_back('{4'b1111, 137, 5'b11100});

      repeat (3) tick();
      chk("reset_ho8", o0, 5'b11100);
      chk("reset_ho0", o1, 5'b11100);
      rst_n = 1'b1;
      cyc = 0;
      foreach (vq[i]) begin
         {br_mb, bgack_mb, bg_cpu, as_cpu} = vq[i].stim;
         while (cyc < vq[i].e) tick();
         chk($sformatf("vec%0d", i), o0, vq[i].want);
      end

      // reset in the middle of a DMA tenure, request still held
      rst_n = 1'b0;
      {br_mb, bgack_mb, bg_cpu, as_cpu} = 4'b1111;
      tick();
      rst_n = 1'b1;
      br_mb = 1'b0;
      repeat (3) tick();
      chk("own_req", 5'(o0[4]), 5'd0);
      bg_cpu = 1'b0;
      repeat (3) tick();
      chk("own_grant", 5'(o0[3]), 5'd0);
      bgack_mb = 1'b0;
      repeat (4) tick();
      chk("own_state", o0, 5'b11010);
      rst_n = 1'b0;
      tick();
      chk("rst_own_ho8", o0, 5'b11100);
      chk("rst_own_ho0", o1, 5'b11100);
      rst_n = 1'b1;
      bgack_mb = 1'b1;
      bg_cpu = 1'b1;
      repeat (2) tick();
      chk("rst_sync_wait", 5'(o0[4]), 5'd1);
      tick();
      chk("rst_rereq", 5'(o0[4]), 5'd0);

      // back-to-back tenure with no hold-off
      bg_cpu = 1'b0;
      repeat (3) tick();
      bgack_mb = 1'b0;
      repeat (4) tick();
      chk("b2b_own", o1, 5'b11010);
      bg_cpu = 1'b1;
      bgack_mb = 1'b1;
      repeat (3) tick();
      chk("b2b_release", o1, 5'b11100);
      tick();
      chk("b2b_idle", o1, 5'b11100);
      tick();
      chk("b2b_rereq", o1, 5'b01100);
      chk("b2b_holdoff8", o0, 5'b11100);

      // acknowledge and withdrawal seen on the same edge in GRANT
      rst_n = 1'b0;
      {br_mb, bgack_mb, bg_cpu, as_cpu} = 4'b1111;
      tick();
      rst_n = 1'b1;
      br_mb = 1'b0;
      repeat (3) tick();
      bg_cpu = 1'b0;
      repeat (3) tick();
      chk("tie_grant", o0, 5'b00100);
      br_mb = 1'b1;
      bgack_mb = 1'b0;
      repeat (3) tick();
      chk("tie_ack_ho8", o0, 5'b01010);
      chk("tie_ack_ho0", o1, 5'b01010);

      // random traffic, including occasional resets
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(9) == 0) br_mb = ~br_mb;
         if ($urandom_range(5) == 0) bg_cpu = ~bg_cpu;
         if ($urandom_range(11) == 0) bgack_mb = ~bgack_mb;
         if ($urandom_range(3) == 0) as_cpu = ~as_cpu;
         rst_n = ($urandom_range(299) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
